// File: rtl/rr_grant_fsm.sv
// Round-robin grant FSM: registered one-hot grant with hold limit,
// forced pre-emption and a one-cycle idle gap on every handover.
module rr_grant_fsm #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [IW-1:0] LAST_ID = IW'(N - 1);
    localparam logic [HW-1:0] HMAX    = HW'(MAX_HOLD);
    localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          preempt_q, preempt_d;

    logic [IW-1:0] win;
    logic [IW-1:0] ptr_after_owner;
    logic          others_req;

    // First requester found scanning upward from the rotation pointer, wrapping at N.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic [IW-1:0] idx_v;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx   = (int'(p) + i) % N;
            idx_v = IW'(idx);
            if (!found && r[idx_v]) begin
                w     = idx_v;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win             = pick(req, ptr_q);
    assign ptr_after_owner = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IW'(1);
    assign others_req      = |(req & ~gnt_q);

    // Next-state and next-output decode; owner is whoever gnt_id_q names.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d  = GRANT;
                    gnt_d    = ONE_N << win;
                    gnt_id_d = win;
                    hcnt_d   = HW'(1);
                end else begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Voluntary release takes priority over a coincident timeout.
                    state_d  = GAP;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = ptr_after_owner;
                end else if ((hcnt_q == HMAX) && others_req) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    ptr_d     = ptr_after_owner;
                    preempt_d = 1'b1;
                end else if (hcnt_q != HMAX) begin
                    // Saturate so a lone owner can hold indefinitely.
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q != IDLE);
    assign preempt = preempt_q;

endmodule
